// File: rtl/syn_pcm_frame_buf_if.sv
// Sample-writer, frame-reader and random-read signals of the PCM frame buffer.
// Latency: none (wiring only).
// Backpressure: wr_rdy stalls the writer, frm_rdy gates the reader's frame claims.
interface syn_pcm_frame_buf_if #(
    parameter int P_DATA_W    = 32,
    parameter int P_ADDR_W    = 7,
    parameter int P_NUM_CHNLS = 2,
    parameter int P_NUM_BANKS = 3
);
    localparam int BANK_W = $clog2(P_NUM_BANKS);
    localparam int CHAN_W = (P_NUM_CHNLS > 1) ? $clog2(P_NUM_CHNLS) : 1;
    localparam int CNT_W  = $clog2(P_NUM_BANKS + 1);

    // writer side
    logic                wr_valid;
    logic [P_DATA_W-1:0] wr_data;
    logic                wr_rdy;
    // frame ownership handshake
    logic                frm_rdy;
    logic                frm_take;
    logic                frm_rel;
    logic [BANK_W-1:0]   frm_bank;
    logic                frm_busy;
    // random read port
    logic                rd_en;
    logic [CHAN_W-1:0]   rd_chan;
    logic [P_ADDR_W-1:0] rd_addr;
    logic                rd_valid;
    logic [P_DATA_W-1:0] rd_data;
    // status
    logic [CNT_W-1:0]    ready_cnt;
    logic                ovf;

    modport slave (
        input  wr_valid, wr_data, frm_take, frm_rel, rd_en, rd_chan, rd_addr,
        output wr_rdy, frm_rdy, frm_bank, frm_busy, rd_valid, rd_data, ready_cnt, ovf
    );

    modport master (
        output wr_valid, wr_data, frm_take, frm_rel, rd_en, rd_chan, rd_addr,
        input  wr_rdy, frm_rdy, frm_bank, frm_busy, rd_valid, rd_data, ready_cnt, ovf
    );
endinterface

// File: rtl/syn_pcm_frame_buf.sv
// Multi-bank PCM frame buffer: writer fills a bank, full banks queue FIFO-ordered, reader claims/reads/releases one.
// Latency: rd_valid/rd_data exactly P_RD_DELAY clocks after rd_en; bank state changes take effect on the next edge.
// Backpressure: wr_rdy drops when no bank can be filled; writes seen while low are dropped and flag sticky ovf.
module syn_pcm_frame_buf #(
    parameter int P_DATA_W    = 32,
    parameter int P_ADDR_W    = 7,
    parameter int P_NUM_CHNLS = 2,
    parameter int P_NUM_BANKS = 3,
    parameter int P_RD_DELAY  = 2
) (
    input  logic               clk_ir,
    input  logic               rst_ih,
    syn_pcm_frame_buf_if.slave bus
);
    localparam int D      = 1 << P_ADDR_W;
    localparam int BANK_W = $clog2(P_NUM_BANKS);
    localparam int CHAN_W = (P_NUM_CHNLS > 1) ? $clog2(P_NUM_CHNLS) : 1;
    localparam int CNT_W  = $clog2(P_NUM_BANKS + 1);
    localparam int DEPTH  = P_NUM_BANKS * P_NUM_CHNLS * D;
    localparam int MEM_AW = $clog2(DEPTH);

    typedef enum logic [1:0] {ST_FREE, ST_FILL, ST_READY, ST_BUSY} bank_st_e;

    bank_st_e              st_q [P_NUM_BANKS];
    bank_st_e              st_d [P_NUM_BANKS];
    logic [BANK_W-1:0]     rq_q [P_NUM_BANKS];   // ready queue, oldest at index 0
    logic [BANK_W-1:0]     rq_d [P_NUM_BANKS];
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BANK_W-1:0]     fill_q, fill_d;       // current (or most recent) FILL bank
    logic                  fill_vld_q, fill_vld_d;
    logic [CHAN_W-1:0]     chan_q, chan_d;
    logic [P_ADDR_W-1:0]   addr_q, addr_d;
    logic                  busy_q, busy_d;
    logic [BANK_W-1:0]     bank_q, bank_d;
    logic                  ovf_q, ovf_d;
    logic [P_RD_DELAY-1:0] rv_q, rv_d;
    logic [P_DATA_W-1:0]   rdat_q [P_RD_DELAY];
    logic [P_DATA_W-1:0]   rdat_d [P_RD_DELAY];

    logic [P_DATA_W-1:0]   mem [DEPTH];

    logic                  wr_acc, frm_done, rel_ok, take_ok, rd_hit, found;
    logic [BANK_W-1:0]     push_idx, rr_idx;
    logic [MEM_AW-1:0]     wr_idx, rd_idx;
    logic [P_DATA_W-1:0]   rd_word;

    assign wr_acc   = bus.wr_valid & fill_vld_q;
    assign frm_done = wr_acc && (chan_q == CHAN_W'(P_NUM_CHNLS - 1)) && (addr_q == '1);
    assign rel_ok   = bus.frm_rel & busy_q;
    // a release in the same cycle frees the reader slot before the take is judged
    assign take_ok  = bus.frm_take && (cnt_q != '0) && (!busy_q || bus.frm_rel);
    // the completed bank lands behind what remains after this cycle's pop
    assign push_idx = take_ok ? BANK_W'(cnt_q - CNT_W'(1)) : BANK_W'(cnt_q);

    assign wr_idx = MEM_AW'(int'(fill_q) * P_NUM_CHNLS * D + int'(chan_q) * D + int'(addr_q));
    assign rd_idx = MEM_AW'(int'(bank_q) * P_NUM_CHNLS * D + int'(bus.rd_chan) * D + int'(bus.rd_addr));
    assign rd_hit = bus.rd_en && busy_q && (int'(bus.rd_chan) < P_NUM_CHNLS);
    assign rd_word = rd_hit ? mem[rd_idx] : '0;

    // Next-state for bank ownership, ready queue, write counters and reader claim
    always_comb begin
        st_d       = st_q;
        rq_d       = rq_q;
        cnt_d      = cnt_q + CNT_W'(frm_done) - CNT_W'(take_ok);
        fill_d     = fill_q;
        fill_vld_d = fill_vld_q;
        chan_d     = chan_q;
        addr_d     = addr_q;
        busy_d     = busy_q;
        bank_d     = bank_q;
        ovf_d      = ovf_q | (bus.wr_valid & ~fill_vld_q);
        found      = 1'b0;
        rr_idx     = '0;

        // addr wraps to 0 on the frame's last sample, so counters clear on completion
        if (wr_acc) begin
            if (chan_q == CHAN_W'(P_NUM_CHNLS - 1)) begin
                chan_d = '0;
                addr_d = addr_q + P_ADDR_W'(1);
            end else begin
                chan_d = chan_q + CHAN_W'(1);
            end
        end

        if (rel_ok) begin
            st_d[bank_q] = ST_FREE;
            busy_d       = 1'b0;
        end

        if (take_ok) begin
            st_d[rq_q[0]] = ST_BUSY;
            busy_d        = 1'b1;
            bank_d        = rq_q[0];
            for (int i = 0; i < P_NUM_BANKS - 1; i++) begin
                rq_d[i] = rq_q[i + 1];
            end
        end

        if (frm_done) begin
            st_d[fill_q]   = ST_READY;
            rq_d[push_idx] = fill_q;
            fill_vld_d     = 1'b0;
        end

        // pick the next FILL bank round-robin; a bank released this cycle is
        // still BUSY in st_q and so only becomes eligible on the following edge
        if (frm_done || !fill_vld_q) begin
            for (int k = 1; k <= P_NUM_BANKS; k++) begin
                rr_idx = BANK_W'((int'(fill_q) + k) % P_NUM_BANKS);
                if (!found && st_q[rr_idx] == ST_FREE) begin
                    found        = 1'b1;
                    st_d[rr_idx] = ST_FILL;
                    fill_d       = rr_idx;
                    fill_vld_d   = 1'b1;
                end
            end
        end
    end

    // Read pipeline: RAM lookup enters stage 0, then shifts P_RD_DELAY-1 more stages
    always_comb begin
        rv_d      = '0;
        rdat_d[0] = rd_word;
        rv_d[0]   = bus.rd_en;
        for (int i = 1; i < P_RD_DELAY; i++) begin
            rv_d[i]   = rv_q[i - 1];
            rdat_d[i] = rdat_q[i - 1];
        end
    end

    // Control and read-pipeline registers with synchronous reset
    always_ff @(posedge clk_ir) begin
        if (rst_ih) begin
            for (int b = 0; b < P_NUM_BANKS; b++) begin
                st_q[b] <= (b == 0) ? ST_FILL : ST_FREE;
                rq_q[b] <= '0;
            end
            cnt_q      <= '0;
            fill_q     <= '0;
            fill_vld_q <= 1'b1;
            chan_q     <= '0;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            bank_q     <= '0;
            ovf_q      <= 1'b0;
            rv_q       <= '0;
            for (int i = 0; i < P_RD_DELAY; i++) begin
                rdat_q[i] <= '0;
            end
        end else begin
            st_q       <= st_d;
            rq_q       <= rq_d;
            cnt_q      <= cnt_d;
            fill_q     <= fill_d;
            fill_vld_q <= fill_vld_d;
            chan_q     <= chan_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            bank_q     <= bank_d;
            ovf_q      <= ovf_d;
            rv_q       <= rv_d;
            rdat_q     <= rdat_d;
        end
    end

    // Sample RAM: contents survive reset
    always_ff @(posedge clk_ir) begin
        if (!rst_ih && wr_acc) begin
            mem[wr_idx] <= bus.wr_data;
        end
    end

    assign bus.wr_rdy    = fill_vld_q;
    assign bus.frm_rdy   = (cnt_q != '0);
    assign bus.frm_bank  = bank_q;
    assign bus.frm_busy  = busy_q;
    assign bus.rd_valid  = rv_q[P_RD_DELAY-1];
    assign bus.rd_data   = rdat_q[P_RD_DELAY-1];
    assign bus.ready_cnt = cnt_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_syn_pcm_frame_buf.sv
// Scenario bench for syn_pcm_frame_buf with a queue-based frame-ownership reference model.
// Latency: model predicts each output one edge at a time, reads P_RD_DELAY edges ahead.
// Backpressure: model drops writes while no FILL bank exists and raises sticky ovf.
module tb_syn_pcm_frame_buf;
    localparam int DW = 32, AW = 2, NC = 2, NB = 3, RD = 2;
    localparam int D  = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    syn_pcm_frame_buf_if #(.P_DATA_W(DW), .P_ADDR_W(AW), .P_NUM_CHNLS(NC), .P_NUM_BANKS(NB)) bus ();

    syn_pcm_frame_buf #(
        .P_DATA_W(DW), .P_ADDR_W(AW), .P_NUM_CHNLS(NC), .P_NUM_BANKS(NB), .P_RD_DELAY(RD)
    ) dut (
        .clk_ir (clk),
        .rst_ih (rst),
        .bus    (bus)
    );

    int vecs = 0;
    int errs = 0;

    // reference model: sets and queues of bank indices, frame position as a sample count
    bit          m_free [NB];
    int          m_rq [$];
    int          m_fill, m_last_fill, m_busy, m_bank, m_pos;
    bit          m_ovf;
    logic [DW-1:0] m_mem [NB][NC][D];
    bit          e_rv [16];
    logic [DW-1:0] e_rd [16];
    int          ecyc = 0;

    task automatic model_reset();
        for (int b = 0; b < NB; b++) m_free[b] = (b != 0);
        m_rq.delete();
        m_fill = 0; m_last_fill = 0; m_busy = -1; m_bank = 0; m_pos = 0; m_ovf = 0;
        for (int i = 0; i < 16; i++) begin e_rv[i] = 0; e_rd[i] = '0; end
    endtask

    task automatic model_step();
        bit fb [NB];
        int done, had_fill, slot;
        if (rst) begin
            model_reset();
            ecyc++;
            return;
        end
        slot = (ecyc + RD - 1) % 16;
        e_rv[slot] = bus.rd_en;
        e_rd[slot] = (bus.rd_en && m_busy >= 0 && int'(bus.rd_chan) < NC)
                     ? m_mem[m_busy][bus.rd_chan][bus.rd_addr] : '0;
        fb = m_free;
        done = -1;
        had_fill = (m_fill >= 0);
        if (bus.wr_valid) begin
            if (m_fill < 0) m_ovf = 1;
            else begin
                m_mem[m_fill][m_pos % NC][m_pos / NC] = bus.wr_data;
                m_pos++;
                if (m_pos == NC * D) begin done = m_fill; m_pos = 0; end
            end
        end
        if (bus.frm_rel && m_busy >= 0) begin m_free[m_busy] = 1; m_busy = -1; end
        if (bus.frm_take && m_rq.size() > 0 && m_busy < 0) begin
            m_busy = m_rq.pop_front();
            m_bank = m_busy;
        end
        if (done >= 0) begin m_rq.push_back(done); m_fill = -1; end
        if (done >= 0 || !had_fill) begin
            for (int k = 1; k <= NB; k++) begin
                int b;
                b = (m_last_fill + k) % NB;
                if (fb[b]) begin m_free[b] = 0; m_fill = b; m_last_fill = b; break; end
            end
        end
        ecyc++;
    endtask

    function automatic logic [6:0] exp_flags();
        return {m_fill >= 0, m_rq.size() != 0, m_busy >= 0, 2'(m_rq.size()), m_ovf, e_rv[(ecyc - 1) % 16]};
    endfunction

    function automatic logic [6:0] act_flags();
        return {bus.wr_rdy, bus.frm_rdy, bus.frm_busy, bus.ready_cnt, bus.ovf, bus.rd_valid};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.wr_valid = 0; bus.wr_data = '0; bus.frm_take = 0; bus.frm_rel = 0;
        bus.rd_en = 0; bus.rd_chan = '0; bus.rd_addr = '0;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1;
        tick(); tick();
        vecs++;
        if (act_flags() !== 7'b1_0_0_00_0_0) begin
            errs++; $display("FAIL reset flags: got %b want %b", act_flags(), 7'b1000000);
        end
        vecs++;
        if (bus.rd_data !== '0 || bus.frm_bank !== '0) begin
            errs++; $display("FAIL reset data/bank: got %h/%0d want 0/0", bus.rd_data, bus.frm_bank);
        end
        rst = 0;
    endtask

    task automatic test_fill_frame();
        for (int i = 1; i <= 8; i++) begin
            bus.wr_valid = 1; bus.wr_data = DW'(i);
            tick();
            vecs++;
            if (act_flags() !== exp_flags()) begin
                errs++; $display("FAIL fill flags: got %b want %b", act_flags(), exp_flags());
            end
        end
        set_idle();
        vecs++;
        if (bus.frm_rdy !== 1'b1 || bus.ready_cnt !== 2'd1 || bus.wr_rdy !== 1'b1) begin
            errs++; $display("FAIL fill done: got rdy=%b cnt=%0d wr_rdy=%b want 1/1/1",
                             bus.frm_rdy, bus.ready_cnt, bus.wr_rdy);
        end
    endtask

    task automatic test_take_read();
        logic [DW-1:0] got [$];
        logic [DW-1:0] want [4];
        want = '{32'd2, 32'd4, 32'd6, 32'd8};
        bus.frm_take = 1;
        tick();
        bus.frm_take = 0;
        for (int c = 0; c < 7; c++) begin
            bus.rd_en = (c < 4); bus.rd_chan = 1'b1; bus.rd_addr = AW'(c);
            tick();
            if (bus.rd_valid) got.push_back(bus.rd_data);
            vecs++;
            if (act_flags() !== exp_flags() || bus.rd_data !== e_rd[(ecyc - 1) % 16]) begin
                errs++; $display("FAIL take_read c%0d: got %b/%h want %b/%h", c, act_flags(),
                                 bus.rd_data, exp_flags(), e_rd[(ecyc - 1) % 16]);
            end
        end
        set_idle();
        vecs++;
        if (bus.frm_bank !== 2'd0 || got.size() != 4) begin
            errs++; $display("FAIL take_read bank/count: got %0d/%0d want 0/4", bus.frm_bank, got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vecs++;
                if (got[i] !== want[i]) begin
                    errs++; $display("FAIL take_read data%0d: got %0d want %0d", i, got[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 17; i++) begin
            bus.wr_valid = 1; bus.wr_data = $urandom;
            tick();
            vecs++;
            if (act_flags() !== exp_flags()) begin
                errs++; $display("FAIL backpressure flags w%0d: got %b want %b", i, act_flags(), exp_flags());
            end
        end
        set_idle();
        vecs++;
        if (bus.wr_rdy !== 1'b0 || bus.ovf !== 1'b1 || bus.ready_cnt !== 2'd2) begin
            errs++; $display("FAIL backpressure state: got wr_rdy=%b ovf=%b cnt=%0d want 0/1/2",
                             bus.wr_rdy, bus.ovf, bus.ready_cnt);
        end
    endtask

    task automatic test_rel_take_same();
        bus.frm_rel = 1; bus.frm_take = 1;
        tick();
        set_idle();
        vecs++;
        if (bus.frm_bank !== 2'd1 || bus.ready_cnt !== 2'd1 || bus.wr_rdy !== 1'b0 || bus.frm_busy !== 1'b1) begin
            errs++; $display("FAIL rel_take: got bank=%0d cnt=%0d wr_rdy=%b busy=%b want 1/1/0/1",
                             bus.frm_bank, bus.ready_cnt, bus.wr_rdy, bus.frm_busy);
        end
        tick();
        vecs++;
        if (bus.wr_rdy !== 1'b1 || act_flags() !== exp_flags()) begin
            errs++; $display("FAIL rel_take refill: got %b want %b", act_flags(), exp_flags());
        end
    endtask

    task automatic test_complete_take();
        bus.frm_rel = 1;
        tick();
        bus.frm_rel = 0;
        for (int i = 0; i < 8; i++) begin
            bus.wr_valid = 1; bus.wr_data = $urandom; bus.frm_take = (i == 7);
            tick();
            vecs++;
            if (act_flags() !== exp_flags()) begin
                errs++; $display("FAIL complete_take flags w%0d: got %b want %b", i, act_flags(), exp_flags());
            end
        end
        set_idle();
        vecs++;
        if (bus.frm_bank !== 2'd2 || bus.ready_cnt !== 2'd1 || bus.wr_rdy !== 1'b1) begin
            errs++; $display("FAIL complete_take: got bank=%0d cnt=%0d wr_rdy=%b want 2/1/1",
                             bus.frm_bank, bus.ready_cnt, bus.wr_rdy);
        end
    endtask

    task automatic test_reset_midframe();
        logic [DW-1:0] got;
        got = '1;
        for (int i = 0; i < 3; i++) begin bus.wr_valid = 1; bus.wr_data = $urandom; tick(); end
        bus.wr_valid = 0; bus.rd_en = 1; bus.rd_addr = 2'd1;
        tick();
        rst = 1;
        tick();
        rst = 0;
        set_idle();
        vecs++;
        if (act_flags() !== 7'b1_0_0_00_0_0) begin
            errs++; $display("FAIL midreset flags: got %b want %b", act_flags(), 7'b1000000);
        end
        for (int i = 1; i <= 8; i++) begin bus.wr_valid = 1; bus.wr_data = DW'(100 + i); tick(); end
        bus.wr_valid = 0; bus.frm_take = 1;
        tick();
        bus.frm_take = 0; bus.rd_en = 1; bus.rd_chan = 1'b0; bus.rd_addr = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            bus.rd_en = 0;
            if (bus.rd_valid) got = bus.rd_data;
            vecs++;
            if (act_flags() !== exp_flags() || bus.rd_data !== e_rd[(ecyc - 1) % 16]) begin
                errs++; $display("FAIL midreset read c%0d: got %b/%h want %b/%h", c, act_flags(),
                                 bus.rd_data, exp_flags(), e_rd[(ecyc - 1) % 16]);
            end
        end
        vecs++;
        if (bus.frm_bank !== 2'd0 || got !== 32'd101) begin
            errs++; $display("FAIL midreset refill: got bank=%0d data=%0d want 0/101", bus.frm_bank, got);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            rst           = ($urandom_range(0, 199) == 0);
            bus.wr_valid  = ($urandom_range(0, 9) < 6);
            bus.wr_data   = $urandom;
            bus.frm_take  = ($urandom_range(0, 9) < 3);
            bus.frm_rel   = ($urandom_range(0, 9) < 2);
            bus.rd_en     = ($urandom_range(0, 1) == 1);
            bus.rd_chan   = 1'($urandom_range(0, NC - 1));
            bus.rd_addr   = AW'($urandom_range(0, D - 1));
            tick();
            vecs++;
            if (act_flags() !== exp_flags() || bus.rd_data !== e_rd[(ecyc - 1) % 16]) begin
                errs++; $display("FAIL random c%0d: got %b/%h want %b/%h", c, act_flags(),
                                 bus.rd_data, exp_flags(), e_rd[(ecyc - 1) % 16]);
            end
            vecs++;
            if (m_busy >= 0 && bus.frm_bank !== 2'(m_bank)) begin
                errs++; $display("FAIL random bank c%0d: got %0d want %0d", c, bus.frm_bank, m_bank);
            end
        end
        rst = 0;
        set_idle();
    endtask

    initial begin
        model_reset();
        set_idle();
        test_reset();
        test_fill_frame();
        test_take_read();
        test_backpressure();
        test_rel_take_same();
        test_complete_take();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
